product_hex_scanner: RTL and testbench

Downstream display stage for the 8×8 multiplier datapath. It captures the 16-bit product on a one-cycle valid pulse and time-multiplexes it onto a four-digit common-cathode 7-segment display as four hex digits, most significant digit first. It adds per-digit blanking gaps, optional leading-zero suppression, a frame-marker decimal point and a scan-hold input. Its outputs drive the board display pins in place of the raw product byte mux.

---
 rtl/product_hex_scanner_pkg.sv | 35 +++
 rtl/product_hex_scanner_hex_to_seg.sv | 14 +
 rtl/product_hex_scanner.sv | 140 ++++++++++++++
 tb/tb_product_hex_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/product_hex_scanner_pkg.sv
// Shared definitions for the product hex scanner: FSM state type,
// segment encoding table and blank pattern.
package disp_pkg;

    // Scanner FSM states; encodings fixed so they match legacy probes.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex digit to {g,f,e,d,c,b,a}, active high; entry n is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, // F
        7'h79, // E
        7'h5E, // d
        7'h39, // C
        7'h7C, // b
        7'h77, // A
        7'h6F, // 9
        7'h7F, // 8
        7'h07, // 7
        7'h7D, // 6
        7'h6D, // 5
        7'h66, // 4
        7'h4F, // 3
        7'h5B, // 2
        7'h06, // 1
        7'h3F  // 0
    };

endpackage

// File: rtl/product_hex_scanner_hex_to_seg.sv
// Combinational 4-bit hex to 7-segment decoder driven by the shared table.
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/product_hex_scanner.sv
// Four-digit multiplexed hex display of a captured 16-bit product.
// Each digit slot is TICK_DIV cycles, the first BLANK_CYCLES of which are
// dark; the MSD is scanned first and carries the frame-marker decimal point.
module product_hex_scanner
    import disp_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 50,
    parameter int unsigned LZ_BLANK     = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        result_valid,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    localparam logic [15:0] CNT_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(BLANK_CYCLES - 1);

    state_t      state;
    logic [15:0] cap;
    logic [15:0] cnt;
    logic [1:0]  idx;

    logic [3:0]  nibble;
    logic        lead_zero;
    logic [6:0]  dec_seg;

    logic [6:0]  seg_next;
    logic        dp_next;
    logic [1:0]  digit_idx_next;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Scan FSM, slot counter, digit index and product capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cap   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (result_valid) begin
            // A new product restarts the frame at the MSD, overriding hold.
            cap   <= result;
            state <= ST_GAP;
            idx   <= 2'd3;
            cnt   <= '0;
        end else if (!hold) begin
            case (state)
                ST_GAP: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == GAP_LAST) begin
                        state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        idx   <= idx - 2'd1;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Select the active nibble and detect whether it is a leading zero.
    always_comb begin
        nibble    = cap[3:0];
        lead_zero = 1'b0;
        case (idx)
            2'd3: begin
                nibble    = cap[15:12];
                lead_zero = (cap[15:12] == 4'h0);
            end
            2'd2: begin
                nibble    = cap[11:8];
                lead_zero = (cap[15:8] == 8'h00);
            end
            2'd1: begin
                nibble    = cap[7:4];
                lead_zero = (cap[15:4] == 12'h000);
            end
            default: begin
                nibble    = cap[3:0];
                lead_zero = 1'b0;
            end
        endcase
    end

    // Next display values from the current state, counter, index and capture.
    always_comb begin
        seg_next       = SEG_OFF;
        dp_next        = 1'b0;
        digit_idx_next = idx;
        case (state)
            ST_IDLE: begin
                digit_idx_next = 2'd0;
            end
            ST_SHOW: begin
                if ((LZ_BLANK != 0) && lead_zero) begin
                    seg_next = SEG_OFF;
                end else begin
                    seg_next = dec_seg;
                end
                dp_next = (idx == 2'd3);
            end
            default: begin
                seg_next = SEG_OFF;
            end
        endcase
    end

    // Output registers; while held the state is frozen so they stay constant.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg       <= SEG_OFF;
            dp        <= 1'b0;
            digit_idx <= 2'd0;
        end else begin
            seg       <= seg_next;
            dp        <= dp_next;
            digit_idx <= digit_idx_next;
        end
    end

endmodule

// File: tb/tb_product_hex_scanner.sv
// Directed self-checking bench for product_hex_scanner (TICK_DIV=8, BLANK_CYCLES=2).
module tb_product_hex_scanner;

    localparam int unsigned TD = 8;
    localparam int unsigned BC = 2;

    logic        clk;
    logic        reset;
    logic [15:0] result;
    logic        result_valid;
    logic        hold;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] value;
        logic [6:0]  s3;
        logic [6:0]  s2;
        logic [6:0]  s1;
        logic [6:0]  s0;
    } vec_t;

    vec_t vecs [8];

    product_hex_scanner #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC),
        .LZ_BLANK     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_valid (result_valid),
        .hold         (hold),
        .seg          (seg),
        .dp           (dp),
        .digit_idx    (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] es, input logic ed, input logic [1:0] ei);
        n_cmp++;
        if (seg !== es || dp !== ed || digit_idx !== ei) begin
            n_err++;
            $display("FAIL %s: got seg=%02h dp=%0b idx=%0d, want seg=%02h dp=%0b idx=%0d",
                     name, seg, dp, digit_idx, es, ed, ei);
        end
    endtask

    // One-cycle capture pulse; result is scrambled afterwards to show it is ignored.
    task automatic pulse(input logic [15:0] v);
        result       = v;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        result       = ~v;
    endtask

    function automatic logic [6:0] pick(input vec_t v, input int unsigned d);
        case (d)
            3: return v.s3;
            2: return v.s2;
            1: return v.s1;
            default: return v.s0;
        endcase
    endfunction

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        result       = 16'h0000;
        result_valid = 1'b0;
        hold         = 1'b0;

        vecs[0] = '{16'h12AF, 7'h06, 7'h5B, 7'h77, 7'h71};
        vecs[1] = '{16'h0005, 7'h00, 7'h00, 7'h00, 7'h6D};
        vecs[2] = '{16'h0000, 7'h00, 7'h00, 7'h00, 7'h3F};
        vecs[3] = '{16'h0500, 7'h00, 7'h6D, 7'h3F, 7'h3F};
        vecs[4] = '{16'hABCD, 7'h77, 7'h7C, 7'h39, 7'h5E};
        vecs[5] = '{16'h8F30, 7'h7F, 7'h71, 7'h4F, 7'h3F};
        vecs[6] = '{16'h0090, 7'h00, 7'h00, 7'h6F, 7'h3F};
        vecs[7] = '{16'h4567, 7'h66, 7'h6D, 7'h7D, 7'h07};

        // Reset held three cycles, then idle with no stimulus.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", 7'h00, 1'b0, 2'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("idle", 7'h00, 1'b0, 2'd0);
        end

        // Full frame plus wrap for each vector, cycle by cycle.
        for (int v = 0; v < 8; v++) begin
            pulse(vecs[v].value);
            for (int k = 1; k <= 4 * TD + 3; k++) begin
                int unsigned slot;
                int unsigned pos;
                int unsigned d;
                logic [6:0]  es;
                logic        ed;
                step();
                slot = (k - 1) / TD;
                pos  = (k - 1) % TD;
                d    = (3 - slot) & 3;
                if (pos < BC) begin
                    es = 7'h00;
                    ed = 1'b0;
                end else begin
                    es = pick(vecs[v], d);
                    ed = (d == 3);
                end
                chk($sformatf("frame_%04h_k%0d", vecs[v].value, k), es, ed, 2'(d));
            end
        end

        // Hold during digit 2 SHOW, capture during hold, then release.
        pulse(16'h12AF);
        for (int i = 0; i < 13; i++) step();
        chk("hold_pre", 7'h5B, 1'b0, 2'd2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_frozen", 7'h5B, 1'b0, 2'd2);
        end
        result       = 16'hFFFF;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        result       = 16'h0000;
        step();
        chk("hold_recap", 7'h00, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_recap_frozen", 7'h00, 1'b0, 2'd3);
        end
        hold = 1'b0;
        step();
        chk("release_dark0", 7'h00, 1'b0, 2'd3);
        step();
        chk("release_dark1", 7'h00, 1'b0, 2'd3);
        step();
        chk("release_lit", 7'h71, 1'b1, 2'd3);

        // New capture while digit 1 is lit aborts the slot.
        pulse(16'h12AF);
        for (int i = 0; i < 20; i++) step();
        chk("abort_pre", 7'h77, 1'b0, 2'd1);
        pulse(16'hABCD);
        step();
        chk("abort_dark0", 7'h00, 1'b0, 2'd3);
        step();
        chk("abort_dark1", 7'h00, 1'b0, 2'd3);
        step();
        chk("abort_lit", 7'h77, 1'b1, 2'd3);

        // Reset during digit 2 SHOW returns to IDLE until the next capture.
        pulse(16'h12AF);
        for (int i = 0; i < 12; i++) step();
        chk("rst_pre", 7'h5B, 1'b0, 2'd2);
        reset = 1'b1;
        step();
        chk("rst_mid", 7'h00, 1'b0, 2'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rst_idle", 7'h00, 1'b0, 2'd0);
        end
        pulse(16'h0500);
        step();
        chk("rst_recap", 7'h00, 1'b0, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
